// File: rtl/seq_comp_pkg.sv
// rtl/seq_comp_pkg.sv - shared states and result codes for the sequential magnitude comparator
package seq_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/rel_chunk.sv
// rtl/rel_chunk.sv - combinational K-bit unsigned chunk compare, exactly one of eq/gr/le high
module rel_chunk #(
  parameter int K = 1
) (
  input  logic [K-1:0] a_i,
  input  logic [K-1:0] b_i,
  output logic         eq_o,
  output logic         gr_o,
  output logic         le_o
);

  assign eq_o = (a_i == b_i);
  assign gr_o = (a_i >  b_i);
  assign le_o = (a_i <  b_i);

endmodule

// File: rtl/seq_mag_comp.sv
// rtl/seq_mag_comp.sv - MSB-first K-bits-per-cycle magnitude comparator with early exit
module seq_mag_comp
  import seq_comp_pkg::*;
#(
  parameter int W = 8,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         signed_mode,
  output logic         busy,
  output logic         done,
  output logic [2:0]   o
);

  localparam int NCH = W / K;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  if (W < 2 || K < 1 || K > W || (W % K) != 0) begin : g_bad_params
    $error("seq_mag_comp: illegal W/K combination");
  end

  state_e        state_q;
  logic [W-1:0]  xs_q, ys_q;
  logic [W-1:0]  xs_d, ys_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    o_q;
  logic          busy_q, done_q;
  logic [W-1:0]  sign_flip;
  logic          chunk_eq, chunk_gr, chunk_le;

  // Flipping the sign bit maps two's complement onto offset binary, so one unsigned scan serves both modes.
  assign sign_flip = {signed_mode, {(W-1){1'b0}}};
  assign xs_d      = xs_q << K;
  assign ys_d      = ys_q << K;
  assign cnt_d     = cnt_q + CW'(1);

  rel_chunk #(.K(K)) u_rel_chunk (
    .a_i  (xs_q[W-1 -: K]),
    .b_i  (ys_q[W-1 -: K]),
    .eq_o (chunk_eq),
    .gr_o (chunk_gr),
    .le_o (chunk_le)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      cnt_q   <= '0;
      o_q     <= RES_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            xs_q    <= x ^ sign_flip;
            ys_q    <= y ^ sign_flip;
            cnt_q   <= '0;
            o_q     <= RES_NONE;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SCAN: begin
          if (!chunk_eq) begin
            o_q     <= {chunk_gr, 1'b0, chunk_le};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (cnt_q == LAST) begin
            o_q     <= RES_EQ;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            xs_q  <= xs_d;
            ys_q  <= ys_d;
            cnt_q <= cnt_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign o    = o_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// tb/tb_seq_mag_comp.sv - self-checking bench for seq_mag_comp at K=1 and K=4
module tb_seq_mag_comp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       st1, st4, sm1, sm4;
  logic [7:0] x1, y1, x4, y4;
  logic       b1, b4, d1, d4;
  logic [2:0] o1, o4;
  logic       sel;
  logic       ob, od;
  logic [2:0] oo;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  seq_mag_comp #(.W(8), .K(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .x(x1), .y(y1), .signed_mode(sm1),
    .busy(b1), .done(d1), .o(o1)
  );

  seq_mag_comp #(.W(8), .K(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .x(x4), .y(y4), .signed_mode(sm4),
    .busy(b4), .done(d4), .o(o4)
  );

  always_comb begin
    ob = sel ? b4 : b1;
    od = sel ? d4 : d1;
    oo = sel ? o4 : o1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_o(input logic [7:0] a, input logic [7:0] b, input bit sm);
    int ai, bi;
    ai = sm ? int'($signed(a)) : int'(a);
    bi = sm ? int'($signed(b)) : int'(b);
    if (ai > bi) return 3'b100;
    if (ai < bi) return 3'b001;
    return 3'b010;
  endfunction

  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b, input bit sm, input int k);
    int am, bm, sh;
    am = sm ? (int'(a) + 128) % 256 : int'(a);
    bm = sm ? (int'(b) + 128) % 256 : int'(b);
    for (int i = 0; i < 8 / k; i++) begin
      sh = 8 - k * (i + 1);
      if (((am >> sh) % (1 << k)) != ((bm >> sh) % (1 << k))) return i + 1;
    end
    return 8 / k;
  endfunction

  task automatic start_req(input logic s, input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(negedge clk);
    sel = s;
    if (s) begin x4 = a; y4 = b; sm4 = sm; st4 = 1'b1; end
    else   begin x1 = a; y1 = b; sm1 = sm; st1 = 1'b1; end
    @(posedge clk);
    #1;
    st1 = 1'b0;
    st4 = 1'b0;
    chk("accept_busy", ob, 1);
    chk("accept_o_cleared", oo, 0);
    chk("accept_no_done", od, 0);
  endtask

  task automatic wait_done(input logic [2:0] exp_o, input int exp_lat, input bit noise, input bit follow);
    bit got = 1'b0;
    for (int e = 1; e <= 40 && !got; e++) begin
      if (noise) begin
        @(negedge clk);
        st1 = 1'b1; x1 = 8'($urandom); y1 = 8'($urandom); sm1 = 1'($urandom);
      end
      @(posedge clk);
      #1;
      if (noise) st1 = 1'b0;
      if (od) begin
        got = 1'b1;
        chk("latency", e, exp_lat);
        chk("result", oo, exp_o);
        chk("busy_at_done", ob, 0);
      end else begin
        chk("busy_in_scan", ob, 1);
      end
    end
    chk("done_seen", got, 1);
    if (got && follow) begin
      @(posedge clk);
      #1;
      chk("done_one_pulse", od, 0);
      chk("o_holds", oo, exp_o);
      chk("busy_idle", ob, 0);
    end
  endtask

  initial begin
    logic [7:0] a, b;
    logic       s, sm;
    int         k;
    rst_n = 1'b0;
    sel = 1'b0;
    st1 = 1'b0; st4 = 1'b0; sm1 = 1'b0; sm4 = 1'b0;
    x1 = '0; y1 = '0; x4 = '0; y4 = '0;
    #12;
    chk("rst_busy1", b1, 0);
    chk("rst_done1", d1, 0);
    chk("rst_o1", o1, 0);
    chk("rst_o4", o4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    start_req(0, 8'h40, 8'h80, 0);
    wait_done(3'b001, 1, 0, 1);
    start_req(0, 8'h83, 8'h82, 0);
    wait_done(3'b100, 8, 0, 1);
    start_req(0, 8'h80, 8'h7F, 1);
    wait_done(3'b001, 1, 0, 1);
    start_req(0, 8'h80, 8'h7F, 0);
    wait_done(3'b100, 1, 0, 1);
    start_req(1, 8'h5A, 8'h5A, 0);
    wait_done(3'b010, 2, 0, 1);
    start_req(1, 8'h5B, 8'h5A, 0);
    wait_done(3'b100, 2, 0, 1);

    start_req(0, 8'h01, 8'h00, 0);
    wait_done(3'b100, 8, 1, 0);
    start_req(0, 8'h00, 8'h01, 0);
    wait_done(3'b001, 8, 0, 1);

    start_req(0, 8'h01, 8'h00, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", b1, 0);
    chk("async_rst_done", d1, 0);
    chk("async_rst_o", o1, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_no_done", d1, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_req(0, 8'h10, 8'h10, 0);
    wait_done(3'b010, 8, 0, 1);

    for (int i = 0; i < 40; i++) begin
      s  = 1'($urandom);
      sm = 1'($urandom);
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      k  = s ? 4 : 1;
      start_req(s, a, b, sm);
      wait_done(ref_o(a, b, sm), ref_lat(a, b, sm, k), 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
